ir_pulse_capture: RTL and testbench

IR_PULSE_CAPTURE -- requirements
Module: ir_pulse_capture

---
 rtl/ir_rx_pkg.sv | 19 +
 rtl/ir_rx_fifo.sv | 49 ++++
 rtl/ir_pulse_capture.sv | 153 +++++++++++++++
 tb/tb_ir_pulse_capture.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_rx_pkg.sv
// Shared types and constants for the IR pulse capture block.
package ir_rx_pkg;

  localparam int DUR_WIDTH      = 16;
  localparam int PRESCALE_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_t;

  // One captured pulse: level (1 = mark) and its length in ticks.
  typedef struct packed {
    logic                 level;
    logic [DUR_WIDTH-1:0] duration;
  } entry_t;

endpackage

// File: rtl/ir_rx_fifo.sv
// Synchronous FIFO with async reset, flush and full/empty flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ir_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // Pointer update; flush empties the FIFO without touching storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + (AW+1)'(1);
      if (rd_en) rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage write; contents are only observable through valid pointers.
  always_ff @(posedge clk_i) begin
    if (wr_en && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ir_pulse_capture.sv
// IR pulse capture: measures mark/space durations of a demodulated IR
// receiver output and queues them as {level, duration} entries.
// Optional glitch filter enabled by defining IR_RX_GLITCH_FILTER_EN.
module ir_pulse_capture
  import ir_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DUR_WIDTH  = ir_rx_pkg::DUR_WIDTH
) (
  input  logic                      clock_in,
  input  logic                      reset_in,
  input  logic                      enable_in,
  input  logic                      ir_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale_in,
  input  logic [DUR_WIDTH-1:0]      timeout_in,
  output logic [DUR_WIDTH:0]        data_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic                      frame_end_out,
  output logic                      overflow_out,
  output logic                      busy_out
);

  state_t                    state_q;
  logic                      sync1_q, sync2_q;
  logic                      lvl_q;
  logic                      mark_now, chg, tick;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic [DUR_WIDTH-1:0]      dur_q, dur_d;
  logic                      push_q;
  logic [DUR_WIDTH:0]        push_data_q;
  logic                      frame_end_q, overflow_q;
  logic                      fifo_full, fifo_empty, pop;

  // Two-flop synchronizer; idles high (space) out of reset.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= ir_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef IR_RX_GLITCH_FILTER_EN
  logic [2:0] hist_q;

  // History of the last three synchronized samples for the glitch filter.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) hist_q <= 3'b111;
    else          hist_q <= {hist_q[1:0], sync2_q};
  end

  // Level only moves once four consecutive samples agree.
  assign mark_now = (hist_q == {3{sync2_q}}) ? ~sync2_q : lvl_q;
`else
  assign mark_now = ~sync2_q;
`endif

  assign chg = (mark_now != lvl_q);

  // Prescaler and saturating duration counter next-state.
  always_comb begin
    tick  = (pre_q == prescale_in);
    pre_d = tick ? '0 : pre_q + PRESCALE_WIDTH'(1);
    dur_d = (tick && (dur_q != '1)) ? dur_q + DUR_WIDTH'(1) : dur_q;
  end

  // Capture FSM; the pushed duration includes a tick landing on the change edge.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      lvl_q       <= 1'b0;
      pre_q       <= '0;
      dur_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      frame_end_q <= 1'b0;
    end else if (!enable_in) begin
      state_q     <= ST_IDLE;
      lvl_q       <= 1'b0;
      pre_q       <= '0;
      dur_q       <= '0;
      push_q      <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_end_q <= 1'b0;
      lvl_q       <= mark_now;
      if (chg) begin
        pre_q <= '0;
        dur_q <= '0;
      end else begin
        pre_q <= pre_d;
        dur_q <= dur_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (chg && mark_now) state_q <= ST_MARK;
        end
        ST_MARK: begin
          if (chg) begin
            push_q      <= 1'b1;
            push_data_q <= {1'b1, dur_d};
            state_q     <= ST_SPACE;
          end
        end
        ST_SPACE: begin
          if (chg) begin
            push_q      <= 1'b1;
            push_data_q <= {1'b0, dur_d};
            state_q     <= ST_MARK;
          end else if ((timeout_in != '0) && (dur_q == timeout_in)) begin
            frame_end_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pop = valid_out && ready_in;

  // Sticky overflow: a push lost because the FIFO was full and not draining.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in)                           overflow_q <= 1'b0;
    else if (!enable_in)                    overflow_q <= 1'b0;
    else if (push_q && fifo_full && !pop)   overflow_q <= 1'b1;
  end

  ir_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DUR_WIDTH + 1)
  ) u_fifo (
    .clk_i   (clock_in),
    .rst_i   (reset_in),
    .flush_i (!enable_in),
    .push_i  (push_q),
    .data_i  (push_data_q),
    .pop_i   (pop),
    .data_o  (data_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign valid_out     = !fifo_empty;
  assign frame_end_out = frame_end_q;
  assign overflow_out  = overflow_q;
  assign busy_out      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ir_pulse_capture.sv
// Scoreboard bench for ir_pulse_capture (default parameters).
module tb_ir_pulse_capture;
  import ir_rx_pkg::*;

`ifdef IR_RX_GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        enable_in = 1'b0;
  logic        ir_in = 1'b1;
  logic [7:0]  prescale_in = 8'd0;
  logic [15:0] timeout_in = 16'd0;
  logic [16:0] data_out;
  logic        valid_out;
  logic        ready_in = 1'b1;
  logic        frame_end_out;
  logic        overflow_out;
  logic        busy_out;

  int     checks = 0;
  int     errors = 0;
  int     fe_cnt = 0;
  entry_t exp_q[$];

  ir_pulse_capture dut (
    .clock_in      (clk),
    .reset_in      (reset_in),
    .enable_in     (enable_in),
    .ir_in         (ir_in),
    .prescale_in   (prescale_in),
    .timeout_in    (timeout_in),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .frame_end_out (frame_end_out),
    .overflow_out  (overflow_out),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  function automatic entry_t ent(logic l, logic [15:0] d);
    ent.level    = l;
    ent.duration = d;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare head entry whenever the DUT presents one; pop on handshake.
  always @(negedge clk) begin
    if (frame_end_out) fe_cnt++;
    if (valid_out && !reset_in) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_entry: got %h expected none", data_out);
      end else begin
        if (data_out !== exp_q[0]) begin
          errors++;
          $display("FAIL entry: got %h expected %h", data_out, exp_q[0]);
        end
        if (ready_in) void'(exp_q.pop_front());
      end
    end
  end

  task automatic hold(logic lvl, int n);
    ir_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(string name, int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  task automatic restart();
    enable_in = 1'b0;
    ir_in     = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_valid", 32'(valid_out), 0);
    chk("flush_ovf", 32'(overflow_out), 0);
    chk("flush_busy", 32'(busy_out), 0);
    enable_in = 1'b1;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int fe0;
    // Reset state
    #2;
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_fe", 32'(frame_end_out), 0);
    chk("rst_ovf", 32'(overflow_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_in = 1'b0;
    restart();

    // Latency of the first push
    prescale_in = 8'd0;
    timeout_in  = 16'd0;
    ready_in    = 1'b1;
    exp_q.push_back(ent(1'b1, 16'd10));
    hold(1'b0, 10);
    ir_in = 1'b1;
    k = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (valid_out) begin
        k = i;
        break;
      end
    end
    chk("push_latency", k, LAT);
    drain("lat_drain", 20);
    restart();

    // Short frame with timeout
    prescale_in = 8'd9;
    timeout_in  = 16'd100;
    fe0 = fe_cnt;
    exp_q.push_back(ent(1'b1, 16'd20));
    exp_q.push_back(ent(1'b0, 16'd10));
    exp_q.push_back(ent(1'b1, 16'd5));
    hold(1'b0, 200);
    chk("busy_mark", 32'(busy_out), 1);
    hold(1'b1, 100);
    hold(1'b0, 50);
    hold(1'b1, 1100);
    drain("frame_drain", 20);
    chk("frame_end_cnt", fe_cnt - fe0, 1);
    chk("frame_busy_after", 32'(busy_out), 0);
    restart();

    // Overflow: 10 level changes with consumer stalled
    prescale_in = 8'd0;
    timeout_in  = 16'd0;
    ready_in    = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(ent((i % 2) == 0, 16'(3 + i)));
    for (int i = 0; i < 10; i++) hold((i % 2) != 0, 3 + i);
    hold(1'b1, 20);
    chk("ovf_set", 32'(overflow_out), 1);
    chk("ovf_valid", 32'(valid_out), 1);
    ready_in = 1'b1;
    drain("ovf_drain", 30);
    chk("ovf_sticky", 32'(overflow_out), 1);
    chk("ovf_empty", 32'(valid_out), 0);
    restart();

    // Disable flushes queued entries
    ready_in = 1'b0;
    exp_q.push_back(ent(1'b1, 16'd3));
    exp_q.push_back(ent(1'b0, 16'd4));
    exp_q.push_back(ent(1'b1, 16'd5));
    hold(1'b0, 3);
    hold(1'b1, 4);
    hold(1'b0, 5);
    hold(1'b1, 10);
    chk("dis_valid_before", 32'(valid_out), 1);
    enable_in = 1'b0;
    @(posedge clk);
    #1;
    chk("dis_valid_after", 32'(valid_out), 0);
    chk("dis_ovf", 32'(overflow_out), 0);
    exp_q.delete();
    ready_in = 1'b1;
    restart();

    // Two-clock glitch
`ifndef IR_RX_GLITCH_FILTER_EN
    exp_q.push_back(ent(1'b1, 16'd2));
`endif
    hold(1'b0, 2);
    hold(1'b1, 30);
    drain("glitch_drain", 20);
`ifdef IR_RX_GLITCH_FILTER_EN
    chk("glitch_busy", 32'(busy_out), 0);
`else
    chk("glitch_busy", 32'(busy_out), 1);
`endif
    restart();

    // Asynchronous reset mid-mark
    ready_in = 1'b0;
    exp_q.push_back(ent(1'b1, 16'd5));
    hold(1'b0, 5);
    hold(1'b1, 5);
    hold(1'b0, 10);
    chk("pre_rst_busy", 32'(busy_out), 1);
    #3;
    reset_in = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_out), 0);
    chk("arst_data", 32'(data_out), 0);
    chk("arst_busy", 32'(busy_out), 0);
    chk("arst_ovf", 32'(overflow_out), 0);
    chk("arst_fe", 32'(frame_end_out), 0);
    exp_q.delete();
    ir_in    = 1'b1;
    ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_in = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("arst_no_entry", 32'(valid_out), 0);
    chk("arst_idle", 32'(busy_out), 0);
    restart();

    // Saturation of a very long mark
    fe0 = fe_cnt;
    exp_q.push_back(ent(1'b1, 16'hFFFF));
    hold(1'b0, 70000);
    hold(1'b1, 20);
    drain("sat_drain", 20);
    chk("sat_no_frame_end", fe_cnt - fe0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
